// File: rtl/mcpu_mem_pkg.sv
// Shared types and region decode for the MCPU memory controller.
package mcpu_mem_pkg;

    typedef enum logic [1:0] {D_IDLE, D_BUSY, D_DONE} d_state_t;
    typedef enum logic {F_IDLE, F_DONE} f_state_t;

    // Everything below 2**dram_addr_bits is DRAM; the rest mirrors IROM.
    function automatic logic is_dram(input logic [31:0] addr, input int dram_addr_bits);
        return (addr >> dram_addr_bits) == 32'd0;
    endfunction

endpackage

// File: rtl/mcpu_sync_ram.sv
// Single-port synchronous RAM with registered read; contents are never cleared.
module mcpu_sync_ram #(
    parameter int ADDR_BITS = 14,
    parameter int DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0] wdata,
    output logic [DATA_BITS-1:0] rdata
);

    logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/mcpu_mem_ctrl.sv
// Registered, handshaked MCPU memory controller: fetch port, data port,
// shared IROM with loader write port, private DRAM with wait states.
//
//   state  | meaning
//   D_IDLE | data port waiting for d_req (blocked while load_en)
//   D_BUSY | DRAM wait states counting down
//   D_DONE | d_ready (and d_fault) presented for one cycle
//   F_IDLE | fetch waiting for if_req and a free IROM read port
//   F_DONE | if_ready presented for one cycle
module mcpu_mem_ctrl
    import mcpu_mem_pkg::*;
#(
    parameter int IROM_ADDR_BITS = 12,
    parameter int DRAM_ADDR_BITS = 14,
    parameter int ADDR_BITS      = 16,
    parameter int DATA_BITS      = 16,
    parameter int DRAM_WAIT      = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      if_req,
    input  logic [ADDR_BITS-1:0]      if_addr,
    output logic                      if_ready,
    output logic [7:0]                if_data,
    input  logic                      d_req,
    input  logic                      d_we,
    input  logic [ADDR_BITS-1:0]      d_addr,
    input  logic [DATA_BITS-1:0]      d_wdata,
    output logic                      d_ready,
    output logic [DATA_BITS-1:0]      d_rdata,
    output logic                      d_fault,
    input  logic                      load_en,
    input  logic                      load_we,
    input  logic [IROM_ADDR_BITS-1:0] load_addr,
    input  logic [7:0]                load_data
);

    logic [7:0] irom [2**IROM_ADDR_BITS];

    d_state_t             d_state, d_state_nxt;
    logic [3:0]           wait_cnt, wait_cnt_nxt;
    logic [ADDR_BITS-1:0] addr_r;
    logic                 we_r;
    logic [DATA_BITS-1:0] wdata_r;
    logic                 d_latch, d_access;

    logic [ADDR_BITS-1:0] acc_addr;
    logic                 acc_we;
    logic [DATA_BITS-1:0] acc_wdata;
    logic                 acc_dram;
    logic                 d_irom_rd, ram_en, fault_nxt;

    logic [DATA_BITS-1:0] ram_rdata, irom_rd_r;
    logic                 rd_src_dram;

    f_state_t             f_state, f_state_nxt;
    logic                 f_go;
    logic                 if_addr_unused;

    // An access launched straight from D_IDLE uses the live request; later ones use the latch.
    assign acc_addr  = (d_state == D_IDLE) ? d_addr  : addr_r;
    assign acc_we    = (d_state == D_IDLE) ? d_we    : we_r;
    assign acc_wdata = (d_state == D_IDLE) ? d_wdata : wdata_r;
    assign acc_dram  = is_dram(32'(acc_addr), DRAM_ADDR_BITS);

    always_comb begin
        d_state_nxt  = d_state;
        wait_cnt_nxt = wait_cnt;
        d_latch      = 1'b0;
        d_access     = 1'b0;
        case (d_state)
            D_IDLE: begin
                if (d_req && !load_en) begin
                    d_latch = 1'b1;
                    if (acc_dram && DRAM_WAIT != 0) begin
                        d_state_nxt  = D_BUSY;
                        wait_cnt_nxt = 4'(DRAM_WAIT);
                    end else begin
                        d_state_nxt = D_DONE;
                        d_access    = 1'b1;
                    end
                end
            end
            D_BUSY: begin
                wait_cnt_nxt = wait_cnt - 4'd1;
                if (wait_cnt == 4'd1) begin
                    d_state_nxt = D_DONE;
                    d_access    = 1'b1;
                end
            end
            D_DONE:  d_state_nxt = D_IDLE;
            default: d_state_nxt = D_IDLE;
        endcase
    end

    assign d_irom_rd = d_access && !acc_dram && !acc_we;
    assign fault_nxt = d_access && !acc_dram && acc_we;
    // Gated by reset so an aborted write never reaches the array.
    assign ram_en    = d_access && acc_dram && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            d_state     <= D_IDLE;
            wait_cnt    <= 4'd0;
            addr_r      <= '0;
            we_r        <= 1'b0;
            wdata_r     <= '0;
            d_fault     <= 1'b0;
            irom_rd_r   <= '0;
            rd_src_dram <= 1'b0;
        end else begin
            d_state  <= d_state_nxt;
            wait_cnt <= wait_cnt_nxt;
            d_fault  <= fault_nxt;
            if (d_latch) begin
                addr_r  <= d_addr;
                we_r    <= d_we;
                wdata_r <= d_wdata;
            end
            if (d_irom_rd) irom_rd_r <= DATA_BITS'(irom[acc_addr[IROM_ADDR_BITS-1:0]]);
            if (d_access && !acc_we) rd_src_dram <= acc_dram;
        end
    end

    mcpu_sync_ram #(
        .ADDR_BITS (DRAM_ADDR_BITS),
        .DATA_BITS (DATA_BITS)
    ) u_dram (
        .clk   (clk),
        .en    (ram_en),
        .we    (acc_we),
        .addr  (acc_addr[DRAM_ADDR_BITS-1:0]),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    assign d_ready = (d_state == D_DONE);
    assign d_rdata = rd_src_dram ? ram_rdata : irom_rd_r;

    // Fetch yields the IROM read port to the data port on any shared edge.
    always_comb begin
        f_state_nxt = f_state;
        f_go        = 1'b0;
        case (f_state)
            F_IDLE: begin
                if (if_req && !load_en && !d_irom_rd) begin
                    f_go        = 1'b1;
                    f_state_nxt = F_DONE;
                end
            end
            F_DONE:  f_state_nxt = F_IDLE;
            default: f_state_nxt = F_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_state <= F_IDLE;
            if_data <= 8'h00;
        end else begin
            f_state <= f_state_nxt;
            if (f_go) if_data <= irom[if_addr[IROM_ADDR_BITS-1:0]];
        end
    end

    assign if_ready       = (f_state == F_DONE);
    assign if_addr_unused = ^if_addr[ADDR_BITS-1:IROM_ADDR_BITS];

    always_ff @(posedge clk) begin
        if (load_en && load_we) irom[load_addr] <= load_data;
    end

endmodule

// File: tb/tb_mcpu_mem_ctrl.sv
// Directed bench for mcpu_mem_ctrl: instance a uses DRAM_WAIT=1, instance b DRAM_WAIT=3.
module tb_mcpu_mem_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic        reset, if_req, d_req, d_we, load_en, load_we;
    logic [15:0] if_addr, d_addr, d_wdata;
    logic [11:0] load_addr;
    logic [7:0]  load_data;
    logic        if_ready, d_ready, d_fault;
    logic [7:0]  if_data;
    logic [15:0] d_rdata;

    logic        b_reset, b_d_req, b_d_we;
    logic [15:0] b_d_addr, b_d_wdata;
    logic        b_if_ready, b_d_ready, b_d_fault;
    logic [7:0]  b_if_data;
    logic [15:0] b_d_rdata;

    mcpu_mem_ctrl #(.DRAM_WAIT(1)) u_dut_a (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata), .d_fault(d_fault),
        .load_en(load_en), .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
    );

    mcpu_mem_ctrl #(.DRAM_WAIT(3)) u_dut_b (
        .clk(clk), .reset(b_reset),
        .if_req(1'b0), .if_addr(16'h0000), .if_ready(b_if_ready), .if_data(b_if_data),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_ready(b_d_ready), .d_rdata(b_d_rdata), .d_fault(b_d_fault),
        .load_en(1'b0), .load_we(1'b0), .load_addr(12'h000), .load_data(8'h00)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        load_en = 1'b0; load_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0; load_addr = '0; load_data = '0;
        b_reset = 1'b1; b_d_req = 1'b0; b_d_we = 1'b0; b_d_addr = '0; b_d_wdata = '0;
        step(); step();
        reset = 1'b0; b_reset = 1'b0;

        check_val("rst if_ready", 32'(if_ready), 0);
        check_val("rst if_data",  32'(if_data),  0);
        check_val("rst d_ready",  32'(d_ready),  0);
        check_val("rst d_rdata",  32'(d_rdata),  0);
        check_val("rst d_fault",  32'(d_fault),  0);

        // DRAM write then read, two cycles each
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0010; d_wdata = 16'h1234;
        step(); check_val("dwr wait ready", 32'(d_ready), 0);
        step(); check_val("dwr ready", 32'(d_ready), 1);
        check_val("dwr fault", 32'(d_fault), 0);
        d_req = 1'b0; step();
        d_req = 1'b1; d_we = 1'b0;
        step(); check_val("drd wait ready", 32'(d_ready), 0);
        step(); check_val("drd ready", 32'(d_ready), 1);
        check_val("drd rdata", 32'(d_rdata), 32'h1234);
        check_val("drd fault", 32'(d_fault), 0);
        d_req = 1'b0; step();

        // loader writes two bytes
        load_en = 1'b1; load_we = 1'b1; load_addr = 12'h005; load_data = 8'hA7;
        step();
        load_addr = 12'h006; load_data = 8'h3C;
        step();
        load_en = 1'b0; load_we = 1'b0;

        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h4005;
        step(); check_val("irom rd ready", 32'(d_ready), 1);
        check_val("irom rd rdata", 32'(d_rdata), 32'h00A7);
        check_val("irom rd fault", 32'(d_fault), 0);
        d_req = 1'b0; step();
        d_req = 1'b1; d_addr = 16'hF005;
        step(); check_val("irom mirror rdata", 32'(d_rdata), 32'h00A7);
        d_req = 1'b0; step();

        if_req = 1'b1; if_addr = 16'h0005;
        step(); check_val("fetch ready", 32'(if_ready), 1);
        check_val("fetch data", 32'(if_data), 32'hA7);
        if_req = 1'b0; step();
        check_val("fetch ready low", 32'(if_ready), 0);

        // write to IROM faults and leaves the byte intact
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h4005; d_wdata = 16'hBEEF;
        step(); check_val("fault ready", 32'(d_ready), 1);
        check_val("fault flag", 32'(d_fault), 1);
        d_req = 1'b0; d_we = 1'b0; step();
        check_val("fault clears", 32'(d_fault), 0);
        d_req = 1'b1;
        step(); check_val("after fault rdata", 32'(d_rdata), 32'h00A7);
        check_val("after fault flag", 32'(d_fault), 0);
        d_req = 1'b0; step();

        // fetch and data IROM read on the same edge
        if_req = 1'b1; if_addr = 16'h0006;
        d_req = 1'b1; d_addr = 16'h4005;
        step(); check_val("conf d_ready", 32'(d_ready), 1);
        check_val("conf d_rdata", 32'(d_rdata), 32'h00A7);
        check_val("conf if_ready early", 32'(if_ready), 0);
        d_req = 1'b0;
        step(); check_val("conf if_ready", 32'(if_ready), 1);
        check_val("conf if_data", 32'(if_data), 32'h3C);
        if_req = 1'b0; step();

        // loader ownership blocks both ports
        load_en = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
        if_req = 1'b1; if_addr = 16'h0005;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("load d_ready", 32'(d_ready), 0);
            check_val("load if_ready", 32'(if_ready), 0);
        end
        load_en = 1'b0;
        step(); check_val("unload if_ready", 32'(if_ready), 1);
        check_val("unload if_data", 32'(if_data), 32'hA7);
        if_req = 1'b0;
        step(); check_val("unload d_ready", 32'(d_ready), 1);
        check_val("unload d_rdata", 32'(d_rdata), 32'h1234);
        d_req = 1'b0; step();

        // DRAM_WAIT=3 instance: seed 0x0020, then abort an overwrite with reset
        b_d_req = 1'b1; b_d_we = 1'b1; b_d_addr = 16'h0020; b_d_wdata = 16'h1111;
        step(); step(); step();
        check_val("b wr wait", 32'(b_d_ready), 0);
        step(); check_val("b wr ready", 32'(b_d_ready), 1);
        b_d_req = 1'b0; b_d_we = 1'b0; step();
        b_d_req = 1'b1;
        step(); step(); step();
        check_val("b rd wait", 32'(b_d_ready), 0);
        step(); check_val("b rd ready", 32'(b_d_ready), 1);
        check_val("b rd rdata", 32'(b_d_rdata), 32'h1111);
        b_d_req = 1'b0; step();

        b_d_req = 1'b1; b_d_we = 1'b1; b_d_wdata = 16'h2222;
        step();
        step();
        b_reset = 1'b1; b_d_req = 1'b0; b_d_we = 1'b0;
        step();
        check_val("b rst d_ready", 32'(b_d_ready), 0);
        check_val("b rst d_rdata", 32'(b_d_rdata), 0);
        check_val("b rst d_fault", 32'(b_d_fault), 0);
        check_val("b rst if_ready", 32'(b_if_ready), 0);
        check_val("b rst if_data", 32'(b_if_data), 0);
        b_reset = 1'b0;
        step();
        check_val("b idle after rst", 32'(b_d_ready), 0);
        b_d_req = 1'b1;
        step(); step(); step(); step();
        check_val("b post rst ready", 32'(b_d_ready), 1);
        check_val("b post rst rdata", 32'(b_d_rdata), 32'h1111);
        b_d_req = 1'b0; step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
